// File: rtl/neuron_mac_node.sv
// rtl/neuron_mac_node.sv - fixed-point multiply-accumulate neuron node with bias, saturation and optional ReLU
//
// Accumulates N_IN signed in_data*in_weight products at full precision, adds the
// bias (aligned to the product's fractional point), rescales to DATA_W with
// saturation, optionally applies ReLU, and holds the result until it is consumed.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, bias         begin an inference (IDLE only); bias captured on accept
//   in_valid/in_ready   operand pair handshake; in_data, in_weight operands
//   busy                high in every state except IDLE
//   out_valid/out_ready result handshake; node_res result
//   overflow            sticky saturation flag for the current/last inference
module neuron_mac_node #(
    parameter int N_IN    = 784,
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int ACC_W   = 80,
    parameter int RELU_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] node_res,
    output logic              overflow
);

    generate
        if (ACC_W < 2*DATA_W + $clog2(N_IN) + 1) begin : g_acc_w_check
            $error("neuron_mac_node: ACC_W too small for N_IN full-precision products");
        end
    endgenerate

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);

    // Signed DATA_W limits, widened to the accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_BIAS, S_ACT, S_DONE} state_t;

    state_t             state, state_nx;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  bias_q;

    logic [2*DATA_W-1:0]      prod;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W-1:0]         bias_ext;
    logic signed [ACC_W-1:0]  act_val;
    logic                     sat_hi, sat_lo;
    logic [DATA_W-1:0]        clamped;
    logic [DATA_W-1:0]        res_nx;

    // Operands are sign-extended to 2*DATA_W first, so the truncated unsigned
    // product is the exact two's complement signed product.
    assign prod     = {{DATA_W{in_data[DATA_W-1]}}, in_data} *
                      {{DATA_W{in_weight[DATA_W-1]}}, in_weight};
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // The product carries 2*FRAC_W fractional bits; bias is shifted to match.
    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} << FRAC_W;
    assign act_val  = $signed(acc) >>> FRAC_W;

    always_comb begin
        sat_hi  = (act_val > MAX_V);
        sat_lo  = (act_val < MIN_V);
        clamped = act_val[DATA_W-1:0];
        if (sat_hi) begin
            clamped = MAX_V[DATA_W-1:0];
        end else if (sat_lo) begin
            clamped = MIN_V[DATA_W-1:0];
        end
        res_nx = clamped;
        if ((RELU_EN != 0) && clamped[DATA_W-1]) begin
            res_nx = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ACCUM;
            S_ACCUM: if (in_valid && (cnt == LAST_IDX)) state_nx = S_BIAS;
            S_BIAS:  state_nx = S_ACT;
            S_ACT:   state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = (state == S_ACCUM);
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            bias_q   <= '0;
            node_res <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        bias_q   <= bias;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BIAS: begin
                    acc <= acc + bias_ext;
                end
                S_ACT: begin
                    node_res <= res_nx;
                    if (sat_hi || sat_lo) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_mac_node.md
NEURON_MAC_NODE -- requirements
Module: neuron_mac_node

Interface
REQ-001 SHALL have parameter N_IN, default 784, number of input/weight pairs per inference (≥1).
REQ-002 SHALL have parameter DATA_W, default 32, width of inputs, weights, bias and result (signed two's complement, fixed point).
REQ-003 SHALL have parameter FRAC_W, default 16, fractional bits of every DATA_W operand.
REQ-004 SHALL have parameter ACC_W, default 80, accumulator width; elaboration SHALL fail if ACC_W < 2*DATA_W + $clog2(N_IN) + 1.
REQ-005 SHALL have parameter RELU_EN, default 1, 1 = apply ReLU to the result, 0 = pass it through.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port start  input  1  begin inference; sampled only in IDLE.
REQ-009 SHALL have port bias  input  DATA_W  node bias; captured on the accepted start.
REQ-010 SHALL have port in_valid  input  1  in_data/in_weight pair valid.
REQ-011 SHALL have port in_ready  output  1  node accepts a pair this cycle.
REQ-012 SHALL have port in_data  input  DATA_W  activation operand.
REQ-013 SHALL have port in_weight  input  DATA_W  weight operand.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port out_valid  output  1  node_res valid.
REQ-016 SHALL have port out_ready  input  1  consumer accepts node_res.
REQ-017 SHALL have port node_res  output  DATA_W  activated, saturated node result.
REQ-018 SHALL have port overflow  output  1  sticky: saturation occurred in the current/last inference.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, BIAS, ACT, DONE.
REQ-020 IDLE: start=1 SHALL clear the accumulator, the pair counter and overflow, capture bias, and go to ACCUM; start in any other state SHALL be ignored.
REQ-021 in_ready SHALL equal 1 exactly when state is ACCUM (combinational from state only).
REQ-022 ACCUM: on in_valid && in_ready, acc SHALL become acc + sign-extended full 2*DATA_W product in_data*in_weight, and the counter SHALL increment; in_valid low SHALL stall with no change.
REQ-023 The handshake accepting pair N_IN-1 (counter == N_IN-1) SHALL move to BIAS; no further pairs accepted.
REQ-024 BIAS: acc SHALL become acc + (sign-extended bias << FRAC_W); next state ACT.
REQ-025 ACT: value = acc >>> FRAC_W (arithmetic, truncation toward minus infinity); if value exceeds the signed DATA_W range it SHALL clamp to max/min and set overflow.
REQ-026 ACT: if RELU_EN=1 and the clamped value is negative, node_res SHALL be 0; node_res SHALL be registered, out_valid set to 1, next state DONE.
REQ-027 out_valid SHALL rise on the second rising edge after the edge accepting the final pair.
REQ-028 DONE: node_res and out_valid SHALL hold stable until out_valid && out_ready; that edge SHALL clear out_valid and go to IDLE.
REQ-029 start asserted in the same cycle as the DONE handshake SHALL be ignored; a new inference begins at the earliest one cycle later.
REQ-030 node_res and overflow SHALL retain their last values in IDLE until the next accepted start.
REQ-031 Accumulator arithmetic SHALL be full-precision within ACC_W; no intermediate saturation.

Reset
REQ-032 reset=1 at a rising edge SHALL force state IDLE, acc=0, counter=0, node_res=0, out_valid=0, overflow=0, busy=0, in_ready=0, from any state, including mid-ACCUM and DONE.
REQ-033 reset SHALL take priority over start and all handshakes in the same cycle.

Verification (N_IN=4, DATA_W=32, FRAC_W=16, ACC_W=80)
REQ-034 start, bias=0, four pairs 0x00010000*0x00008000, out_ready=1 -> node_res=0x00020000, overflow=0, out_valid exactly 2 edges after 4th accept.
REQ-035 RELU_EN=1, pairs 0x00010000*0xFFFF0000 x4, bias=0x00010000 -> node_res=0; RELU_EN=0 -> node_res=0xFFFD0000.
REQ-036 pairs 0x7FFF0000*0x7FFF0000 x4 -> node_res=0x7FFFFFFF, overflow=1; next start clears overflow.
REQ-037 in_valid toggled with random gaps, out_ready held low 10 cycles -> same result as REQ-034, node_res stable, start pulses during busy ignored.
REQ-038 reset asserted after 2 accepted pairs -> next edge all outputs at reset values; fresh inference then yields correct result.
